frotaegis_mc_data_gen: RTL and testbench
========================================

// Module: frotaegis_mc_data_gen
// PURPOSE
//  Multi-channel, multi-mode stimulus generator feeding the Frotaegis capture path.
//  Emits CHANNELS parallel DATA_SIZE-bit lanes as bursts of DATA_NUM beats, with a programmable idle gap between bursts.
//  Unlike the single-lane generator, it supports Valid/Ready backpressure, selectable patterns, burst counting and a clean stop.
// PARAMETERS
//  DATA_SIZE    4   bits per lane
//  CHANNELS     4   number of parallel lanes
//  DATA_NUM     16  beats per burst (>=1)
//  GAP_SIZE     8   width of gap_cycles
//  BURST_SIZE   8   width of num_bursts / burst_cnt
// PORTS
//  clk          in   1                    single clock
//  rst          in   1                    async reset, active-high
//  start        in   1                    pulse; begins a run when IDLE, ignored otherwise
//  stop         in   1                    pulse/level; ends run after the current beat is accepted
//  mode         in   2                    0=count 1=LFSR 2=walking-one 3=constant; sampled at start
//  seed         in   DATA_SIZE            pattern seed; sampled at start
//  gap_cycles   in   GAP_SIZE             idle cycles between bursts; sampled at start
//  num_bursts   in   BURST_SIZE           bursts per run, 0=continuous; sampled at start
//  Ready        in   1                    sink accepts beat when Valid&&Ready
//  Valid        out  1                    beat present
//  Data         out  CHANNELS*DATA_SIZE   lane c at [c*DATA_SIZE +: DATA_SIZE]
//  Last         out  1                    high with final beat of each burst
//  busy         out  1                    high in any state but IDLE
//  burst_cnt    out  BURST_SIZE           completed bursts this run
// BEHAVIOUR
//  Reset: Valid=0, Last=0, busy=0, Data=0, burst_cnt=0, state=IDLE, all lane regs=0. Reset mid-burst aborts immediately.
//  FSM: IDLE -start-> BURST (next cycle Valid=1, beat 0, burst_cnt cleared).
//   BURST: beat index advances only on Valid&&Ready; Data/Last held stable while Valid&&!Ready.
//   Accept of beat DATA_NUM-1: burst_cnt+1; if stop seen or burst_cnt+1==num_bursts (num_bursts!=0) -> IDLE;
//   else if gap_cycles==0 -> BURST (back-to-back, Valid stays 1); else -> GAP.
//   GAP: Valid=0 for exactly gap_cycles cycles, then BURST; stop in GAP -> IDLE next cycle.
//  stop is latched (sticky) while busy; honoured at the next beat acceptance or in GAP; cleared on entering IDLE.
//   Run ends at that beat even mid-burst (Last not asserted for a truncated burst).
//  start and stop same cycle in IDLE: stop wins, stays IDLE. start while busy: ignored.
//  Last = Valid && beat index==DATA_NUM-1.
//  Lane patterns (lane c, updated on each accepted beat, restart from seed at each burst start):
//   mode0: lane = seed + c + k (k=beat index), mod 2^DATA_SIZE wrap.
//   mode1: per-lane 16-bit Galois LFSR, poly 0xB400, init {seed,c} zero-extended XOR 16'hACE1
//          (never all-zero); lane = LFSR[DATA_SIZE-1:0]; shifts once per accepted beat.
//   mode2: one-hot, lane starts 1<<((seed+c) mod DATA_SIZE), rotates left one bit per beat.
//   mode3: lane = seed for all beats.
//  Beat index width = clog2(DATA_NUM) (min 1); burst_cnt saturates at all-ones in continuous mode.
//  Latency: start to first Valid = 1 cycle; registered outputs only, no comb path Ready->Valid.
// TESTING
//  1 mode0, seed=3, DATA_NUM=16, CHANNELS=4, num_bursts=1, Ready=1 -> lane0 3..2 wrap (3,4..F,0,1,2), lane1 starts 4; Last on beat 15; burst_cnt=1; busy low next cycle.
//  2 mode0, Ready toggled 1/0 every cycle -> Data/Last frozen in every Ready=0 cycle, 16 beats accepted over 31 cycles, no beat lost or duplicated.
//  3 num_bursts=3, gap_cycles=2 -> 3 bursts of 16 beats, exactly 2 Valid=0 cycles between each; gap_cycles=0 -> 48 contiguous beats.
//  4 mode1, seed=0 -> no lane ever stuck at zero over 64 beats; lane sequences match reference LFSR model bit-exact.
//  5 num_bursts=0, stop at beat 5 of burst 2 with Ready=1 -> last beat accepted is beat 5, Last never high on it, IDLE next cycle, burst_cnt=1.
//  6 rst asserted mid-burst with Valid=1 -> Valid/busy/Last/Data/burst_cnt all 0 same cycle; start after release -> run restarts at beat 0.

Source files
------------

// File: rtl/frotaegis_mc_data_gen.sv
// frotaegis_mc_data_gen: multi-lane patterned burst generator with valid/ready backpressure
module frotaegis_mc_data_gen #(
  parameter int DATA_SIZE  = 4,
  parameter int CHANNELS   = 4,
  parameter int DATA_NUM   = 16,
  parameter int GAP_SIZE   = 8,
  parameter int BURST_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [1:0]                   mode,
  input  logic [DATA_SIZE-1:0]         seed,
  input  logic [GAP_SIZE-1:0]          gap_cycles,
  input  logic [BURST_SIZE-1:0]        num_bursts,
  input  logic                         Ready,
  output logic                         Valid,
  output logic [CHANNELS*DATA_SIZE-1:0] Data,
  output logic                         Last,
  output logic                         busy,
  output logic [BURST_SIZE-1:0]        burst_cnt
);
  localparam int BW = DATA_NUM > 1 ? $clog2(DATA_NUM) : 1;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(DATA_NUM - 1);
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [GAP_SIZE-1:0] gcnt_q, gcnt_d, gap_q, gap_d;
  logic [BURST_SIZE-1:0] cnt_q, cnt_d, nb_q, nb_d;
  logic [1:0] mode_q, mode_d;
  logic [DATA_SIZE-1:0] seed_q, seed_d;
  logic stop_q, stop_d;
  logic [15:0] lane_q [CHANNELS];
  logic [15:0] lane_d [CHANNELS];
  logic go, acc, fin, stop_seen, nb_hit, load;

  // Every lane keeps a 16-bit state; the visible lane value is always its low DATA_SIZE bits.
  function automatic logic [15:0] lane_init(input logic [1:0] m, input logic [DATA_SIZE-1:0] s, input int c);
    logic [15:0] v;
    v = '0;
    case (m)
      2'd0: v[DATA_SIZE-1:0] = s + DATA_SIZE'(c);
      2'd1: v = 16'({s, CW'(c)}) ^ 16'hACE1;
      2'd2: v[DATA_SIZE-1:0] = DATA_SIZE'(1) << ((int'(s) + c) % DATA_SIZE);
      default: v[DATA_SIZE-1:0] = s;
    endcase
    return v;
  endfunction

  function automatic logic [15:0] lane_next(input logic [1:0] m, input logic [15:0] v);
    logic [15:0] n;
    n = '0;
    case (m)
      2'd0: n[DATA_SIZE-1:0] = v[DATA_SIZE-1:0] + DATA_SIZE'(1);
      2'd1: n = v[0] ? (v >> 1) ^ 16'hB400 : v >> 1;
      2'd2: n[DATA_SIZE-1:0] = {v[DATA_SIZE-2:0], v[DATA_SIZE-1]};
      default: n = v;
    endcase
    return n;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      gcnt_q  <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      nb_q    <= '0;
      mode_q  <= '0;
      seed_q  <= '0;
      stop_q  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) lane_q[c] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gcnt_q  <= gcnt_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      stop_q  <= stop_d;
      for (int c = 0; c < CHANNELS; c++) lane_q[c] <= lane_d[c];
    end
  end

  // Next state: a stop (latched or live) ends the run at the next accepted beat or while gapping
  always_comb begin
    go        = start & ~stop;
    acc       = state_q == BURST && Ready;
    fin       = acc && beat_q == LAST_BEAT;
    stop_seen = stop_q | stop;
    nb_hit    = nb_q != '0 && cnt_q + BURST_SIZE'(1) == nb_q;
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = go ? BURST : IDLE;
      BURST:   state_d = !acc ? BURST : (stop_seen || (fin && nb_hit)) ? IDLE : (!fin || gap_q == '0) ? BURST : GAP;
      GAP:     state_d = stop_seen ? IDLE : gcnt_q == GAP_SIZE'(1) ? BURST : GAP;
      default: state_d = IDLE;
    endcase
    load = (state_q == IDLE && go) || (state_q == GAP && state_d == BURST) || (fin && state_d == BURST);
  end

  // Datapath next values: run parameters captured at start, lanes restart from seed at each burst
  always_comb begin
    mode_d = state_q == IDLE && go ? mode : mode_q;
    seed_d = state_q == IDLE && go ? seed : seed_q;
    gap_d  = state_q == IDLE && go ? gap_cycles : gap_q;
    nb_d   = state_q == IDLE && go ? num_bursts : nb_q;
    stop_d = state_d == IDLE ? 1'b0 : stop_seen;
    cnt_d  = state_q == IDLE && go ? '0 : (fin && cnt_q != '1) ? cnt_q + BURST_SIZE'(1) : cnt_q;
    beat_d = load ? '0 : acc ? beat_q + BW'(1) : beat_q;
    gcnt_d = fin && state_d == GAP ? gap_q : state_q == GAP ? gcnt_q - GAP_SIZE'(1) : gcnt_q;
    for (int c = 0; c < CHANNELS; c++)
      lane_d[c] = load ? lane_init(state_q == IDLE ? mode : mode_q, state_q == IDLE ? seed : seed_q, c)
                : acc ? lane_next(mode_q, lane_q[c]) : lane_q[c];
  end

  // Outputs decode registered state only, so Ready never reaches Valid combinationally
  always_comb begin
    Valid     = state_q == BURST;
    busy      = state_q != IDLE;
    Last      = Valid && beat_q == LAST_BEAT;
    burst_cnt = cnt_q;
    Data      = '0;
    for (int c = 0; c < CHANNELS; c++) Data[c*DATA_SIZE +: DATA_SIZE] = lane_q[c][DATA_SIZE-1:0];
  end
endmodule

// File: tb/tb_frotaegis_mc_data_gen.sv
// tb_frotaegis_mc_data_gen: randomized and directed checks against a beat-level reference model
module tb_frotaegis_mc_data_gen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, Ready = 1'b0;
  logic [1:0] mode = '0;
  logic [3:0] seed = '0;
  logic [7:0] gap_cycles = '0, num_bursts = '0;
  logic Valid, Last, busy;
  logic [15:0] Data;
  logic [7:0] burst_cnt;
  int tests = 0, fails = 0;

  frotaegis_mc_data_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .gap_cycles(gap_cycles), .num_bursts(num_bursts), .Ready(Ready),
    .Valid(Valid), .Data(Data), .Last(Last), .busy(busy), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Lane value of beat k, computed directly from the pattern definition
  function automatic int lane_val(input int m, input int s, input int c, input int k);
    int v;
    case (m)
      0: return (s + c + k) % 16;
      1: begin
        v = (s * 4 + c) ^ 'hACE1;
        for (int i = 0; i < k; i++) v = (v & 1) ? ((v >> 1) ^ 'hB400) : (v >> 1);
        return v & 15;
      end
      2: return 1 << ((s + c + k) % 4);
      default: return s;
    endcase
  endfunction

  function automatic logic [15:0] exp_data(input int m, input int s, input int k);
    logic [15:0] d;
    for (int c = 0; c < 4; c++) d[c*4 +: 4] = 4'(lane_val(m, s, c, k));
    return d;
  endfunction

  // Reference model: run/gap bookkeeping in plain integers, compared every cycle on the falling edge
  bit m_act, m_gap, m_sl, sl, ev;
  int m_k, m_cnt, m_gel, m_mode, m_seed, m_gapn, m_nb;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_act = 0; m_gap = 0; m_sl = 0; m_k = 0; m_cnt = 0;
      chk("rst_data", Data, 0);
    end
    ev = m_act && !m_gap;
    chk("valid", Valid, ev);
    chk("busy", busy, m_act);
    chk("last", Last, ev && m_k == 15);
    chk("burst_cnt", burst_cnt, m_cnt);
    if (ev && Valid) chk("data", Data, exp_data(m_mode, m_seed, m_k));
    if (!rst) begin
      if (!m_act) begin
        if (start && !stop) begin
          m_act = 1; m_gap = 0; m_k = 0; m_cnt = 0; m_sl = 0;
          m_mode = mode; m_seed = seed; m_gapn = gap_cycles; m_nb = num_bursts;
        end
      end else begin
        sl = m_sl || stop;
        if (m_gap) begin
          if (sl) m_act = 0;
          else begin
            m_gel++;
            if (m_gel == m_gapn) begin m_gap = 0; m_k = 0; end
          end
        end else if (Ready) begin
          if (m_k == 15) begin
            if (m_cnt != 255) m_cnt++;
            if (sl || (m_nb != 0 && m_cnt == m_nb)) m_act = 0;
            else if (m_gapn == 0) m_k = 0;
            else begin m_gap = 1; m_gel = 0; end
          end else if (sl) m_act = 0;
          else m_k++;
        end
        m_sl = m_act && sl;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int m, input int s, input int g, input int nb);
    mode = 2'(m); seed = 4'(s); gap_cycles = 8'(g); num_bursts = 8'(nb);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int n, acc, nv, cyc;
  bit nz [4];

  initial begin
    repeat (2) step();
    chk("reset_valid", Valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data", Data, 0);
    chk("reset_cnt", burst_cnt, 0);
    rst = 1'b0;
    step();
    // single count burst, seed 3
    Ready = 1'b1;
    launch(0, 3, 0, 1);
    chk("t1_first_valid", Valid, 1);
    chk("t1_beat0", Data, 16'h6543);
    repeat (15) step();
    chk("t1_last", Last, 1);
    chk("t1_beat15", Data, 16'h5432);
    step();
    chk("t1_busy_after", busy, 0);
    chk("t1_cnt", burst_cnt, 1);
    // alternating backpressure
    launch(0, $urandom_range(0, 15), 0, 1);
    cyc = 0;
    while (busy && cyc < 100) begin
      Ready = cyc % 2 == 0;
      step();
      cyc++;
    end
    chk("t2_cycles", cyc, 31);
    Ready = 1'b1;
    // three bursts with gap 2, then back-to-back
    for (int g = 2; g >= 0; g -= 2) begin
      launch(3, $urandom_range(0, 15), g, 3);
      acc = 0; nv = 0; n = 0;
      while (busy && n < 300) begin
        if (Valid) acc++; else nv++;
        step();
        n++;
      end
      chk("t3_beats", acc, 48);
      chk("t3_idle_cycles", nv, 2 * g);
      chk("t3_cnt", burst_cnt, 3);
    end
    // LFSR, seed 0
    launch(1, 0, 1, 4);
    chk("t4_beat0", Data, 16'h2301);
    for (int c = 0; c < 4; c++) nz[c] = 0;
    n = 0;
    while (busy && n < 300) begin
      if (Valid) for (int c = 0; c < 4; c++) if (Data[c*4 +: 4] != 0) nz[c] = 1;
      step();
      n++;
    end
    for (int c = 0; c < 4; c++) chk("t4_lane_nonzero", nz[c], 1);
    // continuous run stopped at beat 5 of burst 2
    launch(0, $urandom_range(0, 15), $urandom_range(0, 3), 0);
    acc = 0; n = 0;
    while (busy && n < 200) begin
      stop = Valid && acc == 21;
      if (Valid) acc++;
      step();
      n++;
    end
    stop = 1'b0;
    chk("t5_beats", acc, 22);
    chk("t5_busy", busy, 0);
    chk("t5_cnt", burst_cnt, 1);
    // start and stop together while idle
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("startstop_idle", busy, 0);
    // reset mid-burst
    launch(2, 5, 0, 0);
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("t6_valid", Valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_last", Last, 0);
    chk("t6_data", Data, 0);
    chk("t6_cnt", burst_cnt, 0);
    step();
    rst = 1'b0;
    launch(2, 5, 0, 1);
    chk("t6_restart", Data, exp_data(2, 5, 0));
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    // randomized runs
    for (int r = 0; r < 25; r++) begin
      stop = $urandom_range(0, 7) == 0;
      launch($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
      stop = 1'b0;
      n = 0;
      while (busy && n < 250) begin
        Ready = $urandom_range(0, 3) != 0;
        stop = $urandom_range(0, 49) == 0 || n > 200;
        start = $urandom_range(0, 15) == 0;
        step();
        n++;
      end
      start = 1'b0; stop = 1'b0; Ready = 1'b1;
      chk("run_end", busy, 0);
      repeat ($urandom_range(1, 3)) step();
    end
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
